// File: rtl/cmd_exec.sv
// cmd_exec: command responder for the robot tour path.
// Accepts 16-bit commands through the cmd_rdy / clr_cmd_rdy / send_resp
// handshake, settles the heading, ramps forward speed up, counts line
// crossings, ramps back down and reports completion.
// Optional feature: define CMD_EXEC_FANFARE_EN so that opcode 4'b0011 pulses
// fanfare_go together with send_resp. Without it, fanfare_go is tied 0.
module cmd_exec #(
  parameter logic [9:0]  FRWRD_INC = 10'd32,
  parameter logic [9:0]  FRWRD_MAX = 10'h2A0,
  parameter logic [11:0] HDNG_TOL  = 12'h02C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  input  logic [11:0] error,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  input  logic        cal_done,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [11:0] dsrd_hdng,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        strt_cal,
  output logic        fanfare_go
);

  typedef enum logic [2:0] {IDLE, CAL, HDNG, RAMP_UP, RAMP_DN, DONE} state_t;

  // Ramp-down step is four ramp-up steps; kept 12 bits wide so it never wraps.
  localparam logic [11:0] DEC_STEP = {FRWRD_INC, 2'b00};

  state_t      r_state;
  logic [3:0]  r_squares;
  logic [4:0]  r_line_cnt;
  logic        r_cntr_ir_q;
  logic [9:0]  r_frwrd;
  logic [11:0] r_dsrd_hdng;
  logic        r_moving;
  logic        r_send_resp;

  logic        w_accept;
  logic [11:0] w_err_abs;
  logic        w_settled;
  logic        w_line_edge;
  logic [10:0] w_frwrd_sum;
  logic [9:0]  w_frwrd_up;
  logic [9:0]  w_frwrd_dn;
  logic [4:0]  w_line_tgt;

  // Handshake acceptance is combinational so the initiator sees it in the same cycle.
  assign w_accept    = (r_state == IDLE) & cmd_rdy & rst_n;
  assign clr_cmd_rdy = w_accept;
  assign strt_cal    = w_accept & (cmd[15:12] == 4'b0000);

  assign w_line_edge = cntrIR & ~r_cntr_ir_q;
  assign w_line_tgt  = {r_squares, 1'b0};
  assign w_settled   = (w_err_abs < HDNG_TOL);

  assign w_frwrd_sum = {1'b0, r_frwrd} + {1'b0, FRWRD_INC};
  assign w_frwrd_up  = (w_frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : w_frwrd_sum[9:0];
  assign w_frwrd_dn  = ({2'b00, r_frwrd} < DEC_STEP) ? 10'd0 : (r_frwrd - DEC_STEP[9:0]);

  // Magnitude of the signed heading error; the most negative code saturates.
  always_comb begin
    // NOTE: default assignment first so no path leaves the output unassigned (no latch).
    w_err_abs = error;
    if (error == 12'h800)
      w_err_abs = 12'h7FF;
    else if (error[11])
      w_err_abs = ~error + 12'd1;
  end

  assign frwrd     = r_frwrd;
  assign dsrd_hdng = r_dsrd_hdng;
  assign moving    = r_moving;
  assign send_resp = r_send_resp;

`ifdef CMD_EXEC_FANFARE_EN
  logic r_fanfare_cmd;
  logic r_fanfare_go;
  assign fanfare_go = r_fanfare_go;

  // Remember whether the accepted move asked for fanfare; pulse it with send_resp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fanfare_cmd <= 1'b0;
      r_fanfare_go  <= 1'b0;
    end else begin
      r_fanfare_go <= 1'b0;
      if (w_accept)
        r_fanfare_cmd <= (cmd[15:12] == 4'b0011);
      if ((r_state == RAMP_DN) && (r_frwrd == 10'd0))
        r_fanfare_go <= r_fanfare_cmd;
    end
  end
`else
  assign fanfare_go = 1'b0;
`endif

  // Main command FSM with registered outputs, line counter and speed ramp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every flop here is control state and is reset; there is no memory array to leave unreset.
      r_state     <= IDLE;
      r_squares   <= 4'd0;
      r_line_cnt  <= 5'd0;
      r_cntr_ir_q <= 1'b0;
      r_frwrd     <= 10'd0;
      r_dsrd_hdng <= 12'h000;
      r_moving    <= 1'b0;
      r_send_resp <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_cntr_ir_q <= cntrIR;
      r_send_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_rdy) begin
            r_squares  <= cmd[3:0];
            r_line_cnt <= 5'd0;
            case (cmd[15:12])
              4'b0000: r_state <= CAL;
              4'b0010, 4'b0011: begin
                r_state     <= HDNG;
                r_moving    <= 1'b1;
                r_frwrd     <= 10'd0;
                r_dsrd_hdng <= (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
              end
              default: begin
                r_state     <= DONE;
                r_send_resp <= 1'b1;
              end
            endcase
          end
        end
        CAL: begin
          if (cal_done) begin
            r_state     <= DONE;
            r_send_resp <= 1'b1;
          end
        end
        HDNG: begin
          if (w_settled)
            r_state <= RAMP_UP;
        end
        RAMP_UP: begin
          if (heading_rdy)
            r_frwrd <= w_frwrd_up;
          if (w_line_edge)
            r_line_cnt <= r_line_cnt + 5'd1;
          if (r_line_cnt == w_line_tgt)
            r_state <= RAMP_DN;
        end
        RAMP_DN: begin
          if (r_frwrd == 10'd0) begin
            r_state     <= DONE;
            r_moving    <= 1'b0;
            r_send_resp <= 1'b1;
          end else if (heading_rdy) begin
            r_frwrd <= w_frwrd_dn;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_exec.sv
// tb_cmd_exec: directed self-checking bench for cmd_exec.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 time unit later, well away from the next active edge.
module tb_cmd_exec;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [11:0] error;
  logic        heading_rdy;
  logic        cntrIR;
  logic        cal_done;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [11:0] dsrd_hdng;
  logic [9:0]  frwrd;
  logic        moving;
  logic        strt_cal;
  logic        fanfare_go;

`ifdef CMD_EXEC_FANFARE_EN
  localparam logic EXP_FAN = 1'b1;
`else
  localparam logic EXP_FAN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cmd_exec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .error       (error),
    .heading_rdy (heading_rdy),
    .cntrIR      (cntrIR),
    .cal_done    (cal_done),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .dsrd_hdng   (dsrd_hdng),
    .frwrd       (frwrd),
    .moving      (moving),
    .strt_cal    (strt_cal),
    .fanfare_go  (fanfare_go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int exp_ramp [27];
  int idx, n_send, n_fan, send_cyc, busy_viol;
  logic [9:0] prev_frwrd;
  logic prev_hrdy, fan_at_send, seen, got_reacc, found;

  initial begin
    // Expected speed sequence for 16'h2BF1: +32 up to 672, then -128 to 0.
    for (int k = 0; k < 21; k++) exp_ramp[k] = 32 * (k + 1);
    exp_ramp[21] = 544; exp_ramp[22] = 416; exp_ramp[23] = 288;
    exp_ramp[24] = 160; exp_ramp[25] = 32;  exp_ramp[26] = 0;

    // ---------------- reset with cmd_rdy held ----------------
    rst_n = 1'b0; cmd = 16'h7123; cmd_rdy = 1'b1; error = 12'h000;
    heading_rdy = 1'b0; cntrIR = 1'b0; cal_done = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_clr",      clr_cmd_rdy, 0);
    check("rst_send",     send_resp,   0);
    check("rst_dsrd",     dsrd_hdng,   0);
    check("rst_frwrd",    frwrd,       0);
    check("rst_moving",   moving,      0);
    check("rst_strt_cal", strt_cal,    0);
    check("rst_fanfare",  fanfare_go,  0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("rel_clr",      clr_cmd_rdy, 1);
    check("rel_strt_cal", strt_cal,    0);

    // ---------------- unknown opcode 16'h7123 ----------------
    tick(); #1;
    check("unk_send",   send_resp,   1);
    check("unk_clr",    clr_cmd_rdy, 0);
    check("unk_frwrd",  frwrd,       0);
    check("unk_moving", moving,      0);
    cmd_rdy = 1'b0;
    tick(); #1;
    check("unk_send_once", send_resp, 0);

    // ---------------- unfanfared move 16'h2BF1 ----------------
    cmd = 16'h2BF1; cmd_rdy = 1'b1; error = 12'h100; #1;
    check("mv_clr", clr_cmd_rdy, 1);
    tick();
    cmd_rdy = 1'b0;
    idx = 0; n_send = 0; n_fan = 0; send_cyc = -1;
    prev_frwrd = 10'd0; prev_hrdy = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      error       = (cyc < 5) ? 12'h100 : 12'h010;
      heading_rdy = (cyc % 4 == 0);
      cntrIR      = (cyc == 118) || (cyc == 122);
      #1;
      if (cyc == 0) begin
        check("mv_dsrd",   dsrd_hdng, 12'hBFF);
        check("mv_moving", moving,    1);
      end
      if (cyc == 60) check("mv_moving_mid", moving, 1);
      if (frwrd != prev_frwrd) begin
        if (idx < 27) check("mv_ramp_val", frwrd, exp_ramp[idx]);
        else          check("mv_ramp_extra", frwrd, prev_frwrd);
        check("mv_ramp_after_strobe", prev_hrdy, 1);
        idx++;
      end
      if (send_resp) begin
        n_send++;
        send_cyc = cyc;
        check("mv_moving_done", moving, 0);
      end
      if (fanfare_go) n_fan++;
      prev_frwrd = frwrd;
      prev_hrdy  = heading_rdy;
      tick();
    end
    heading_rdy = 1'b0; cntrIR = 1'b0;
    check("mv_ramp_steps", idx,       27);
    check("mv_send_count", n_send,    1);
    check("mv_send_cycle", send_cyc,  146);
    check("mv_fanfare",    n_fan,     0);
    check("mv_dsrd_hold",  dsrd_hdng, 12'hBFF);

    // ---------------- calibration 16'h0000 ----------------
    cmd = 16'h0000; cmd_rdy = 1'b1; #1;
    check("cal_strt",     strt_cal,    1);
    check("cal_clr",      clr_cmd_rdy, 1);
    tick();
    cmd_rdy = 1'b0; #1;
    check("cal_strt_once", strt_cal, 0);
    n_send = 0;
    for (int i = 0; i < 9; i++) begin
      if (send_resp) n_send++;
      tick();
    end
    check("cal_wait_no_send", n_send, 0);
    cal_done = 1'b1; #1;
    check("cal_done_cycle_send", send_resp, 0);
    tick();
    cal_done = 1'b0; #1;
    check("cal_send",      send_resp, 1);
    check("cal_moving",    moving,    0);
    check("cal_dsrd_hold", dsrd_hdng, 12'hBFF);
    tick(); #1;
    check("cal_send_once", send_resp, 0);

    // ---------------- fanfare move 16'h3002 ----------------
    cmd = 16'h3002; cmd_rdy = 1'b1; error = 12'h02C; #1;
    check("fan_clr", clr_cmd_rdy, 1);
    tick();
    cmd_rdy = 1'b0; heading_rdy = 1'b1; #1;   // error == tol: not settled
    check("fan_moving", moving,    1);
    check("fan_dsrd",   dsrd_hdng, 12'h000);
    tick();
    error = 12'h800; #1;                     // most negative: not settled
    check("fan_tol_edge", frwrd, 0);
    tick();
    heading_rdy = 1'b0; error = 12'hFD5; #1; // |-0x2B| < tol: settles
    check("fan_err800", frwrd, 0);
    tick();
    error = 12'h000; heading_rdy = 1'b1; #1;
    check("fan_hdng_no_ramp", frwrd, 0);
    tick();
    n_send = 0; n_fan = 0; send_cyc = -1; fan_at_send = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      heading_rdy = (cyc % 4 == 0);
      cntrIR      = (cyc == 4) || (cyc == 8) || (cyc == 12) || (cyc == 16);
      #1;
      if (cyc == 0)  check("fan_settle", frwrd, 32);
      if (cyc == 18) check("fan_final_edge_inc", frwrd, 192);
      if (send_resp) begin
        n_send++;
        send_cyc    = cyc;
        fan_at_send = fanfare_go;
      end
      if (fanfare_go) n_fan++;
      tick();
    end
    heading_rdy = 1'b0; cntrIR = 1'b0;
    check("fan_send_count",  n_send,      1);
    check("fan_send_cycle",  send_cyc,    26);
    check("fan_with_send",   fan_at_send, EXP_FAN);
    check("fan_pulse_count", n_fan,       EXP_FAN);

    // ---------------- busy: cmd_rdy held during a move ----------------
    cmd = 16'h2001; cmd_rdy = 1'b1; error = 12'h000; #1;
    check("busy_clr", clr_cmd_rdy, 1);
    tick();
    busy_viol = 0; seen = 1'b0; got_reacc = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      heading_rdy = (cyc % 4 == 0);
      cntrIR      = (cyc == 40) || (cyc == 41) || (cyc == 48);
      #1;
      if (seen) begin
        check("busy_reaccept", clr_cmd_rdy, 1);
        got_reacc = 1'b1;
        break;
      end
      if (clr_cmd_rdy) busy_viol++;
      if (send_resp) seen = 1'b1;
      tick();
    end
    check("busy_no_clr", busy_viol, 0);
    check("busy_done",   got_reacc, 1);
    heading_rdy = 1'b0; cntrIR = 1'b0;
    tick();

    // ---------------- reset mid RAMP_UP at frwrd == 96 ----------------
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      heading_rdy = (cyc % 4 == 1);
      #1;
      if (frwrd == 10'd96) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst_mid_reach96", found, 1);
    if (found) begin
      rst_n = 1'b0; #1;
      check("rst_mid_frwrd",  frwrd,       0);
      check("rst_mid_moving", moving,      0);
      check("rst_mid_send",   send_resp,   0);
      check("rst_mid_clr",    clr_cmd_rdy, 0);
      n_send = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (send_resp) n_send++;
      end
      check("rst_mid_no_send", n_send, 0);
      heading_rdy = 1'b0; cmd_rdy = 1'b0;
      rst_n = 1'b1;
      tick(); #1;
      check("rst_mid_idle_moving", moving, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
